// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner: double-buffered display data,
// anti-ghosting gaps between digits and optional leading-zero blanking.
`timescale 1ns/1ps
module sseg_scan_ctrl #(
  parameter int unsigned DIGIT_CYC = 100000,
  parameter int unsigned GAP_CYC   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        blank_lz,
  output logic [3:0]  sseg_a_o,
  output logic [6:0]  sseg_c_o,
  output logic        frame_done
);

  // state | meaning
  // IDLE  | display dark; pending data committed at once; waits for en
  // ON    | one anode driven with its decoded digit for DIGIT_CYC cycles
  // GAP   | all anodes off for GAP_CYC cycles before the next digit
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [19:0] DIG_LAST = 20'(DIGIT_CYC - 1);
  localparam logic [19:0] GAP_LAST = 20'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_dig, w_dig_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_disp, r_pend, w_disp_nxt;
  logic        r_pend_full, w_pend_full_nxt;
  logic        w_accept, w_commit, w_end_gap, w_frame;
  logic [3:0]  w_nib, w_an_nxt;
  logic        w_blank;
  logic [6:0]  w_cat_nxt;
  logic [3:0]  r_an;
  logic [6:0]  r_cat;
  logic        r_fd, r_rdy;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_dig_nxt   = r_dig;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_frame     = 1'b0;
    w_end_gap   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_commit = r_pend_full;
        if (en) begin
          w_state_nxt = ST_ON;
          w_dig_nxt   = 2'd0;
          w_cnt_nxt   = 20'd0;
        end
      end
      ST_ON: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_dig_nxt   = 2'd0;
          w_cnt_nxt   = 20'd0;
        end else if (r_cnt == DIG_LAST) begin
          if (GAP_CYC == 0) begin
            w_end_gap = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = 20'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_GAP: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_dig_nxt   = 2'd0;
          w_cnt_nxt   = 20'd0;
        end else if (r_cnt == GAP_LAST) begin
          w_end_gap = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_dig_nxt   = 2'd0;
        w_cnt_nxt   = 20'd0;
      end
    endcase
    // Commit only at a frame boundary so a frame never mixes old and new data.
    if (w_end_gap) begin
      w_state_nxt = ST_ON;
      w_dig_nxt   = r_dig + 2'd1;
      w_cnt_nxt   = 20'd0;
      if (r_dig == 2'd3) begin
        w_frame  = 1'b1;
        w_commit = r_pend_full;
      end
    end
  end

  assign w_accept        = wr_valid & ~r_pend_full;
  assign w_pend_full_nxt = w_commit ? 1'b0 : (w_accept ? 1'b1 : r_pend_full);
  assign w_disp_nxt      = w_commit ? r_pend : r_disp;

  // Outputs are precomputed from next-state values so they register cleanly.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (w_dig_nxt)
      2'd0: w_nib = w_disp_nxt[3:0];
      2'd1: begin
        w_nib   = w_disp_nxt[7:4];
        w_blank = blank_lz & (w_disp_nxt[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = w_disp_nxt[11:8];
        w_blank = blank_lz & (w_disp_nxt[15:8] == 8'h00);
      end
      default: begin
        w_nib   = w_disp_nxt[15:12];
        w_blank = blank_lz & (w_disp_nxt[15:12] == 4'h0);
      end
    endcase
    w_an_nxt  = 4'b1111;
    w_cat_nxt = 7'h7F;
    if (w_state_nxt == ST_ON) begin
      w_an_nxt  = ~(4'b0001 << w_dig_nxt);
      w_cat_nxt = w_blank ? 7'h7F : hex2seg(w_nib);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dig       <= 2'd0;
      r_cnt       <= 20'd0;
      r_disp      <= 16'h0000;
      r_pend      <= 16'h0000;
      r_pend_full <= 1'b0;
      r_rdy       <= 1'b1;
      r_an        <= 4'b1111;
      r_cat       <= 7'h7F;
      r_fd        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dig       <= w_dig_nxt;
      r_cnt       <= w_cnt_nxt;
      r_disp      <= w_disp_nxt;
      if (w_accept) r_pend <= wr_data;
      r_pend_full <= w_pend_full_nxt;
      r_rdy       <= ~w_pend_full_nxt;
      r_an        <= w_an_nxt;
      r_cat       <= w_cat_nxt;
      r_fd        <= w_frame;
    end
  end

  assign wr_ready   = r_rdy;
  assign sseg_a_o   = r_an;
  assign sseg_c_o   = r_cat;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with DIGIT_CYC=4, GAP_CYC=1 (20-cycle frames).
`timescale 1ns/1ps
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        blank_lz = 1'b0;
  logic        wr_ready, frame_done;
  logic [3:0]  sseg_a_o;
  logic [6:0]  sseg_c_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [3:0][6:0] cat4_t;
  typedef struct {
    logic [15:0] data;
    logic        blank;
    cat4_t       ec;
  } vec_t;

  vec_t  vecs[8];
  cat4_t old_c;
  cat4_t c_1234, c_a, c_b, c_zero;

  sseg_scan_ctrl #(.DIGIT_CYC(4), .GAP_CYC(1)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .blank_lz(blank_lz), .sseg_a_o(sseg_a_o),
    .sseg_c_o(sseg_c_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hold_chk(input string nm, input cat4_t oc);
    logic [10:0] e;
    case (sseg_a_o)
      4'b1110: e = {4'b1110, oc[0]};
      4'b1101: e = {4'b1101, oc[1]};
      4'b1011: e = {4'b1011, oc[2]};
      4'b0111: e = {4'b0111, oc[3]};
      default: e = {4'b1111, 7'h7F};
    endcase
    chk(nm, {21'd0, sseg_a_o, sseg_c_o}, {21'd0, e});
  endtask

  // Called at the first sample of a frame; leaves the bench at the next frame's first sample.
  task automatic run_frame(input string nm, input cat4_t ec, input logic fd0);
    for (int k = 0; k < 20; k++) begin
      int d;
      logic [3:0] ea;
      logic [6:0] ecat;
      logic efd;
      d = k / 5;
      if ((k % 5) < 4) begin
        ea   = ~(4'b0001 << d);
        ecat = ec[d];
      end else begin
        ea   = 4'b1111;
        ecat = 7'h7F;
      end
      efd = (k == 0) ? fd0 : 1'b0;
      chk($sformatf("%s k=%0d {fd,an,c}", nm, k),
          {20'd0, frame_done, sseg_a_o, sseg_c_o}, {20'd0, efd, ea, ecat});
      tick();
    end
  endtask

  task automatic wait_fd(input string nm, input cat4_t oc);
    int n;
    n = 0;
    while (!frame_done && n < 60) begin
      hold_chk({nm, " hold old"}, oc);
      tick();
      n++;
    end
    chk({nm, " frame_done seen"}, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wr(input string nm, input logic [15:0] d);
    int n;
    n = 0;
    while (!wr_ready && n < 60) begin
      tick();
      n++;
    end
    chk({nm, " ready before write"}, {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    chk({nm, " ready low after accept"}, {31'd0, wr_ready}, 32'd0);
  endtask

  initial begin
    int n, early, bad;
    c_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    c_a    = {7'h12, 7'h08, 7'h12, 7'h08};
    c_b    = {7'h46, 7'h30, 7'h46, 7'h30};
    c_zero = {7'h40, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{16'h3210, 1'b0, {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[1] = '{16'h7654, 1'b0, {7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[2] = '{16'hBA98, 1'b0, {7'h03, 7'h08, 7'h10, 7'h00}};
    vecs[3] = '{16'hFEDC, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[4] = '{16'h0070, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}};
    vecs[5] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[6] = '{16'h0100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};

    // Reset values
    #23;
    chk("reset anodes", {28'd0, sseg_a_o}, 32'hF);
    chk("reset cathodes", {25'd0, sseg_c_o}, 32'h7F);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();

    // Write while idle and disabled: commit happens in IDLE
    wr("idle write", 16'h1234);
    tick();
    chk("idle commit {rdy,an,c}", {20'd0, wr_ready, sseg_a_o, sseg_c_o}, {20'd0, 1'b1, 4'hF, 7'h7F});
    en = 1'b1;
    tick();
    run_frame("frame1 1234", c_1234, 1'b0);
    run_frame("frame2 1234", c_1234, 1'b1);
    chk("frame3 start fd", {31'd0, frame_done}, 32'd1);
    old_c = c_1234;

    // Mid-frame writes: old value held until frame boundary
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7; j++) begin
        hold_chk($sformatf("vec%0d pre", i), old_c);
        tick();
      end
      wr($sformatf("vec%0d", i), vecs[i].data);
      wait_fd($sformatf("vec%0d", i), old_c);
      chk($sformatf("vec%0d ready after commit", i), {31'd0, wr_ready}, 32'd1);
      blank_lz = vecs[i].blank;
      run_frame($sformatf("vec%0d frame", i), vecs[i].ec, 1'b1);
      old_c = vecs[i].ec;
    end

    // Second write held off while pending, accepted the cycle after commit
    blank_lz = 1'b0;
    tick(); tick(); tick();
    wr_valid = 1'b1;
    wr_data  = 16'h5A5A;
    tick();
    chk("A accepted", {31'd0, wr_ready}, 32'd0);
    wr_data = 16'hC3C3;
    n = 0;
    early = 0;
    while (!frame_done && n < 60) begin
      if (wr_ready) early++;
      tick();
      n++;
    end
    chk("B held off while pending", early, 0);
    chk("A commit {fd,rdy,an,c}", {19'd0, frame_done, wr_ready, sseg_a_o, sseg_c_o},
        {19'd0, 1'b1, 1'b1, 4'b1110, 7'h08});
    tick();
    wr_valid = 1'b0;
    chk("B accepted next cycle", {31'd0, wr_ready}, 32'd0);
    wait_fd("A frame", c_a);
    run_frame("B frame", c_b, 1'b1);

    // Enable dropped during digit 2
    n = 0;
    while (sseg_a_o != 4'b1011 && n < 30) begin
      tick();
      n++;
    end
    chk("reach digit2", {28'd0, sseg_a_o}, 32'hB);
    en = 1'b0;
    tick();
    chk("disable {fd,an,c}", {20'd0, frame_done, sseg_a_o, sseg_c_o}, {20'd0, 1'b0, 4'hF, 7'h7F});
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      if (frame_done || sseg_a_o != 4'hF) bad++;
      tick();
    end
    chk("dark while disabled", bad, 0);
    en = 1'b1;
    tick();
    chk("re-enable digit0 {fd,an,c}", {20'd0, frame_done, sseg_a_o, sseg_c_o},
        {20'd0, 1'b0, 4'b1110, 7'h30});

    // Reset mid-ON with a pending write
    wr("pre-reset write", 16'hFFFF);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async reset {fd,rdy,an,c}", {19'd0, frame_done, wr_ready, sseg_a_o, sseg_c_o},
        {19'd0, 1'b0, 1'b1, 4'hF, 7'h7F});
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_frame("post-reset frame", c_zero, 1'b0);
    chk("post-reset pending discarded {fd,c}", {24'd0, frame_done, sseg_c_o}, {24'd0, 1'b1, 7'h40});
    chk("post-reset wr_ready", {31'd0, wr_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYC, default 100000: clk cycles each digit is driven; legal range 1 to 2^20-1.
REQ-002 Parameter GAP_CYC, default 1000: clk cycles with all anodes off after each digit (anti-ghosting); legal range 0 to 2^20-1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; low means the display is dark.
REQ-006 wr_valid  input  1  write request for new display data.
REQ-007 wr_data  input  16  four hex digits; digit0 = [3:0], digit3 = [15:12].
REQ-008 wr_ready  output  1  pending buffer empty; a write is accepted when wr_valid and wr_ready are both high.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 sseg_a_o  output  4  anode drives, active-low; bit n selects digit n.
REQ-011 sseg_c_o  output  7  cathodes, active-low, {g,f,e,d,c,b,a}.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each digit3 gap.

Function
REQ-013 Storage: disp_reg (16 bits, currently shown) and pend_reg (16 bits) plus pend_full flag; wr_ready SHALL equal ~pend_full.
REQ-014 An accepted write SHALL load pend_reg and set pend_full on the same edge.
REQ-015 FSM states: IDLE, ON, GAP; 2-bit digit index; 20-bit cycle counter.
REQ-016 IDLE: sseg_a_o=4'b1111, sseg_c_o=7'h7F; if pend_full, commit pend_reg to disp_reg and clear pend_full; on en=1, go to ON with digit 0 and counter 0.
REQ-017 ON: assert one anode for the current digit and drive its decoded cathodes; after DIGIT_CYC cycles go to GAP, or, if GAP_CYC=0, act directly as at the end of GAP.
REQ-018 GAP: sseg_a_o=4'b1111 and sseg_c_o=7'h7F for GAP_CYC cycles; then advance the digit (3 wraps to 0) and return to ON.
REQ-019 End of the digit3 gap: pulse frame_done for one cycle; if pend_full, commit to disp_reg and clear pend_full on the same edge. A display frame SHALL never mix old and new data.
REQ-020 en=0 in ON or GAP: on the next edge go to IDLE with anodes off and no frame_done pulse; the next enable restarts at digit 0.
REQ-021 A write in the same cycle as a commit is not accepted (wr_ready is still low); it is accepted on the following cycle.
REQ-022 Decode, active-low hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-023 blank_lz=1: digit n (n=3..1) SHALL show 7'h7F while its anode is active if it and all higher digits are zero; digit0 is never blanked.
REQ-024 All outputs are registered; in ON at most one anode bit is low.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, digit 0, counter 0, disp_reg=0, pend_reg=0, pend_full=0, wr_ready=1, sseg_a_o=4'b1111, sseg_c_o=7'h7F, frame_done=0.
REQ-026 Reset asserted mid-frame SHALL discard any pending write; after release, scanning resumes from IDLE according to en.

Verification (DIGIT_CYC=4, GAP_CYC=1)
REQ-027 Reset, en=1, write 0x1234 while in IDLE:
- commit occurs in IDLE;
- anodes then show 1110/c=19 (4), 1101/c=30 (3), 1011/c=24 (2), 0111/c=79 (1);
- each digit lasts 4 cycles with 1 gap cycle between digits;
- frame_done pulses every 20 cycles.
REQ-028 Write 0x00A0 mid-frame: wr_ready goes low; the display keeps the old value until frame_done; the new value appears on the next digit0; wr_ready returns to 1.
REQ-029 Second write while pend_full: it is held off and only accepted the cycle after the commit.
REQ-030 blank_lz=1 with value 0x0070: digits 3 and 2 show c=7F, digit1 shows 78, digit0 shows 40; value 0x0000 shows only digit0 as 40.
REQ-031 en dropped during digit2: anodes are 1111 on the next edge, with no frame_done; on re-enable, digit0 is asserted first.
REQ-032 reset pulsed low mid-ON with pend_full=1: outputs reach reset values asynchronously, wr_ready=1, and disp_reg=0 is displayed after the next enable.
